// File: rtl/cv32e40p_bb_len_checker.sv
// rtl/cv32e40p_bb_len_checker.sv - basic-block length monitor with discontinuity decode and alarm
module cv32e40p_bb_len_checker #(
    parameter int  MAX_BB_LEN = 8,
    parameter int  CNT_W      = 16,
    localparam int LEN_W      = $clog2(MAX_BB_LEN + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             instr_valid_i,
    input  logic [31:0]      instr_i,
    output logic [LEN_W-1:0] bb_len_o,
    output logic [LEN_W-1:0] max_seen_o,
    output logic [CNT_W-1:0] disc_count_o,
    output logic [CNT_W-1:0] filler_count_o,
    output logic             violation_o,
    output logic             alarm_o,
    output logic [31:0]      violation_instr_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        ALARM   = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BB_LEN);
    localparam logic [LEN_W-1:0] LEN_OVER = LEN_W'(MAX_BB_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [31:0]      FILLER   = 32'h0000006F;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   bb_len_q, bb_len_d;
    logic [LEN_W-1:0]   max_seen_q, max_seen_d;
    logic [CNT_W-1:0]   disc_cnt_q, disc_cnt_d;
    logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic               viol_q, viol_d;
    logic               alarm_q, alarm_d;
    logic [31:0]        vinstr_q, vinstr_d;

    logic               is_disc;
    logic               is_filler;
    logic               accept;

    // Classify the presented word as a control-flow discontinuity (32-bit or compressed)
    always_comb begin
        is_disc = 1'b0;
        if (instr_i[1:0] == 2'b11) begin
            is_disc = (instr_i[6:2] == 5'b11000) ||
                      (instr_i[6:2] == 5'b11011) ||
                      ((instr_i[6:2] == 5'b11001) && (instr_i[14:12] == 3'b000));
        end else if (instr_i[1:0] == 2'b01) begin
            is_disc = (instr_i[15:13] == 3'b001) || (instr_i[15:13] == 3'b101) ||
                      (instr_i[15:13] == 3'b110) || (instr_i[15:13] == 3'b111);
        end else if (instr_i[1:0] == 2'b10) begin
            is_disc = (instr_i[15:13] == 3'b100) && (instr_i[6:2] == 5'b00000) &&
                      (instr_i[11:7] != 5'b00000);
        end
        is_filler = (instr_i == FILLER);
    end

    // Next-state and next-value logic for the FSM and all registered outputs
    always_comb begin
        state_d    = state_q;
        bb_len_d   = bb_len_q;
        max_seen_d = max_seen_q;
        disc_cnt_d = disc_cnt_q;
        fill_cnt_d = fill_cnt_q;
        viol_d     = 1'b0;
        alarm_d    = alarm_q;
        vinstr_d   = vinstr_q;
        accept     = instr_valid_i && (instr_i != 32'h0) && (state_q == MONITOR);

        if (clear_i) begin
            bb_len_d   = '0;
            max_seen_d = '0;
            disc_cnt_d = '0;
            fill_cnt_d = '0;
            alarm_d    = 1'b0;
            vinstr_d   = '0;
            state_d    = enable_i ? MONITOR : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_d  = MONITOR;
                        bb_len_d = '0;
                    end
                end
                MONITOR: begin
                    // A violation takes precedence over a simultaneous enable drop
                    if (accept && !is_disc && (bb_len_q == LEN_MAX)) begin
                        bb_len_d = LEN_OVER;
                        vinstr_d = instr_i;
                        viol_d   = 1'b1;
                        alarm_d  = 1'b1;
                        state_d  = ALARM;
                    end else if (!enable_i) begin
                        bb_len_d = '0;
                        state_d  = IDLE;
                    end else if (accept) begin
                        if (is_disc) begin
                            bb_len_d = '0;
                            if (disc_cnt_q != CNT_SAT) disc_cnt_d = disc_cnt_q + 1'b1;
                            if (is_filler && (fill_cnt_q != CNT_SAT)) fill_cnt_d = fill_cnt_q + 1'b1;
                        end else begin
                            bb_len_d = bb_len_q + 1'b1;
                        end
                    end
                end
                ALARM: begin
                    state_d = ALARM;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (bb_len_d > max_seen_q) max_seen_d = bb_len_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bb_len_q   <= '0;
            max_seen_q <= '0;
            disc_cnt_q <= '0;
            fill_cnt_q <= '0;
            viol_q     <= 1'b0;
            alarm_q    <= 1'b0;
            vinstr_q   <= '0;
        end else begin
            state_q    <= state_d;
            bb_len_q   <= bb_len_d;
            max_seen_q <= max_seen_d;
            disc_cnt_q <= disc_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            viol_q     <= viol_d;
            alarm_q    <= alarm_d;
            vinstr_q   <= vinstr_d;
        end
    end

    assign bb_len_o          = bb_len_q;
    assign max_seen_o        = max_seen_q;
    assign disc_count_o      = disc_cnt_q;
    assign filler_count_o    = fill_cnt_q;
    assign violation_o       = viol_q;
    assign alarm_o           = alarm_q;
    assign violation_instr_o = vinstr_q;

endmodule

// File: tb/tb_cv32e40p_bb_len_checker.sv
// tb/tb_cv32e40p_bb_len_checker.sv - scoreboard bench for the basic-block length checker
module tb_cv32e40p_bb_len_checker;

    localparam int MAX = 4;
    localparam int CW  = 4;
    localparam int LW  = $clog2(MAX + 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic          clear_i;
    logic          instr_valid_i;
    logic [31:0]   instr_i;
    logic [LW-1:0] bb_len_o;
    logic [LW-1:0] max_seen_o;
    logic [CW-1:0] disc_count_o;
    logic [CW-1:0] filler_count_o;
    logic          violation_o;
    logic          alarm_o;
    logic [31:0]   violation_instr_o;

    typedef struct {
        int          len;
        int          mx;
        int          disc;
        int          fill;
        logic        viol;
        logic        alarm;
        logic [31:0] vi;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    cv32e40p_bb_len_checker #(
        .MAX_BB_LEN (MAX),
        .CNT_W      (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable_i          (enable_i),
        .clear_i           (clear_i),
        .instr_valid_i     (instr_valid_i),
        .instr_i           (instr_i),
        .bb_len_o          (bb_len_o),
        .max_seen_o        (max_seen_o),
        .disc_count_o      (disc_count_o),
        .filler_count_o    (filler_count_o),
        .violation_o       (violation_o),
        .alarm_o           (alarm_o),
        .violation_instr_o (violation_instr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int len, input int mx, input int disc, input int fill,
                            input logic viol, input logic alarm, input logic [31:0] vi);
        exp_t e;
        e.len = len; e.mx = mx; e.disc = disc; e.fill = fill;
        e.viol = viol; e.alarm = alarm; e.vi = vi;
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".bb_len"},   32'(bb_len_o),       32'(e.len));
        check({tag, ".max_seen"}, 32'(max_seen_o),     32'(e.mx));
        check({tag, ".disc"},     32'(disc_count_o),   32'(e.disc));
        check({tag, ".filler"},   32'(filler_count_o), 32'(e.fill));
        check({tag, ".viol"},     32'(violation_o),    32'(e.viol));
        check({tag, ".alarm"},    32'(alarm_o),        32'(e.alarm));
        check({tag, ".vinstr"},   violation_instr_o,   e.vi);
    endtask

    task automatic step(input string tag, input logic en, input logic clr, input logic v,
                        input logic [31:0] ins, input int len, input int mx, input int disc,
                        input int fill, input logic viol, input logic alarm, input logic [31:0] vi);
        enable_i      = en;
        clear_i       = clr;
        instr_valid_i = v;
        instr_i       = ins;
        push_exp(len, mx, disc, fill, viol, alarm, vi);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        rst_n = 1'b0; enable_i = 1'b0; clear_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        push_exp(0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        compare_out("reset");
        rst_n = 1'b1;

        step("idle_ignore", 0, 0, 1, 32'h13, 0, 0, 0, 0, 0, 0, 32'h0);

        // Full block ending in the filler jump
        step("enter_mon", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 4; i++)
            step("blk", 1, 0, 1, 32'h13, i, i, 0, 0, 0, 0, 32'h0);
        step("filler", 1, 0, 1, 32'h6F, 0, 4, 1, 1, 0, 0, 32'h0);

        // Over-long block trips the alarm, then everything freezes
        for (int i = 1; i <= 4; i++)
            step("pre_viol", 1, 0, 1, 32'h13, i, 4, 1, 1, 0, 0, 32'h0);
        step("viol", 1, 0, 1, 32'h13, 5, 5, 1, 1, 1, 1, 32'h13);
        step("frozen1", 1, 0, 1, 32'h6F, 5, 5, 1, 1, 0, 1, 32'h13);
        step("frozen2", 1, 0, 1, 32'h63, 5, 5, 1, 1, 0, 1, 32'h13);
        step("clear", 1, 1, 1, 32'h13, 0, 0, 0, 0, 0, 0, 32'h0);
        step("post_clr", 1, 0, 1, 32'h13, 1, 1, 0, 0, 0, 0, 32'h0);

        // Compressed instructions
        step("c_nop1", 1, 0, 1, 32'h0001, 2, 2, 0, 0, 0, 0, 32'h0);
        step("c_nop2", 1, 0, 1, 32'h0001, 3, 3, 0, 0, 0, 0, 32'h0);
        step("c_j",    1, 0, 1, 32'hA001, 0, 3, 1, 0, 0, 0, 32'h0);
        step("c_jr",   1, 0, 1, 32'h8082, 0, 3, 2, 0, 0, 0, 32'h0);
        step("c_mv",   1, 0, 1, 32'h8086, 1, 3, 2, 0, 0, 0, 32'h0);

        // Bubbles and near misses
        step("bubble",    1, 0, 1, 32'h0,    1, 3, 2, 0, 0, 0, 32'h0);
        step("novalid",   1, 0, 0, 32'h13,   1, 3, 2, 0, 0, 0, 32'h0);
        step("jalr_f3_1", 1, 0, 1, 32'h1067, 2, 3, 2, 0, 0, 0, 32'h0);
        step("c_jr_rs0",  1, 0, 1, 32'h8002, 3, 3, 2, 0, 0, 0, 32'h0);

        // Enable drop discards the presented instruction and resets the block
        step("en_drop", 0, 0, 1, 32'h13, 0, 3, 2, 0, 0, 0, 32'h0);
        step("en_back", 1, 0, 0, 32'h0,  0, 3, 2, 0, 0, 0, 32'h0);

        // Saturating discontinuity counter
        for (int i = 1; i <= 20; i++)
            step("sat", 1, 0, 1, 32'h63, 0, 3, ((2 + i) > 15) ? 15 : (2 + i), 0, 0, 0, 32'h0);

        // Violation coinciding with enable drop still lands in ALARM
        step("b1", 1, 0, 1, 32'h13, 1, 3, 15, 0, 0, 0, 32'h0);
        step("b2", 1, 0, 1, 32'h13, 2, 3, 15, 0, 0, 0, 32'h0);
        step("b3", 1, 0, 1, 32'h13, 3, 3, 15, 0, 0, 0, 32'h0);
        step("b4", 1, 0, 1, 32'h13, 4, 4, 15, 0, 0, 0, 32'h0);
        step("viol_endrop", 0, 0, 1, 32'h00100093, 5, 5, 15, 0, 1, 1, 32'h00100093);
        step("alarm_hold",  0, 0, 0, 32'h0,        5, 5, 15, 0, 0, 1, 32'h00100093);
        step("clr_idle",    0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
        step("idle_after",  0, 0, 1, 32'h13,       0, 0, 0, 0, 0, 0, 32'h0);

        // Drive into ALARM again, then reset asynchronously
        step("mon2", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 4; i++)
            step("c2", 1, 0, 1, 32'h13, i, i, 0, 0, 0, 0, 32'h0);
        step("viol2",  1, 0, 1, 32'h13, 5, 5, 0, 0, 1, 1, 32'h13);
        step("alarm2", 1, 0, 0, 32'h0,  5, 5, 0, 0, 0, 1, 32'h13);
        rst_n = 1'b0;
        #1;
        push_exp(0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        compare_out("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", 0, 0, 1, 32'h13, 0, 0, 0, 0, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_bb_len_checker.md
Name: cv32e40p_bb_len_checker

Overview:
- Receiving-end monitor for the discontinuity-insertion path. Sits on the instruction stream after insertion, at the decode input.
- Detects control-flow discontinuities, both real and the inserted filler jump 0x0000006F, and measures basic-block length.
- Raises an alarm when any block exceeds MAX_BB_LEN non-discontinuity instructions. Also keeps saturating statistics for debug and CSR readout.

Parameters:
- MAX_BB_LEN, 8: maximum permitted count of consecutive non-discontinuity instructions; must be ≥ 1.
- CNT_W, 16: width of the statistics counters.
- LEN_W, $clog2(MAX_BB_LEN+2): derived localparam; not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_i  in  1  monitoring enable (level)
- clear_i  in  1  synchronous clear of alarm, counters and statistics
- instr_valid_i  in  1  instr_i carries an instruction this cycle
- instr_i  in  32  instruction word (compressed in [15:0])
- bb_len_o  out  LEN_W  current block length
- max_seen_o  out  LEN_W  largest bb_len reached since clear
- disc_count_o  out  CNT_W  discontinuities accepted, saturating
- filler_count_o  out  CNT_W  filler jumps (0x0000006F) accepted, saturating
- violation_o  out  1  one-cycle pulse on violation
- alarm_o  out  1  sticky violation flag
- violation_instr_o  out  32  instruction that caused the violation

Behaviour:
- Reset: all outputs 0; state IDLE.
- Accept: a cycle with instr_valid_i=1, instr_i≠0, state=MONITOR. An all-zero word is a bubble and never counts.
- Discontinuity decode (combinational, on instr_i):
  - 32-bit (instr_i[1:0]=11):
    - opcode[6:2]=11000 (branch)
    - opcode[6:2]=11011 (JAL)
    - opcode[6:2]=11001 with funct3=000 (JALR)
  - Quadrant 01: funct3 [15:13] ∈ {001, 101, 110, 111} (c.jal, c.j, c.beqz, c.bnez).
  - Quadrant 10: funct3=100, [6:2]=0, [11:7]≠0 (c.jr when [12]=0, c.jalr when [12]=1).
  - Everything else is non-discontinuity; an unmatched JALR funct3 is non-discontinuity.
- Filler: instr_i==32'h0000006F. It is also a discontinuity (JAL), so it increments both disc_count_o and filler_count_o.
- States:
  - IDLE:
    - counters hold; nothing accepted
    - enable_i=1 → MONITOR with bb_len=0
  - MONITOR, on accept:
    - discontinuity: bb_len←0, disc_count+1
    - non-discontinuity with bb_len<MAX_BB_LEN: bb_len+1
    - non-discontinuity with bb_len==MAX_BB_LEN: violation. bb_len←MAX_BB_LEN+1, violation_instr_o←instr_i, violation_o=1 next cycle, alarm_o←1, → ALARM.
    - enable_i=0 → IDLE, bb_len←0; an instruction presented that cycle is not accepted.
  - ALARM:
    - everything frozen; instructions ignored; alarm_o stays 1
    - leaves only via clear_i or reset
- max_seen_o: updated registered, to max(max_seen, next bb_len), same edge as bb_len.
- All outputs registered; latency one clk from accept to visible update.
- Statistics saturate at 2^CNT_W−1; no wrap.
- clear_i (any state, priority over accept and enable):
  - zeroes bb_len, max_seen, counts, alarm and violation_instr
  - next state MONITOR if enable_i=1, else IDLE
  - violation_o never asserts in a clear cycle
- Reset mid-operation (any state): immediate return to the reset values above.
- A violation and a simultaneous enable_i fall: the violation wins and the state goes to ALARM.

Test Plan:
1. Assert/release rst_n while in ALARM → next cycle all outputs 0, state IDLE; 0x00000013 with enable_i=0 leaves bb_len_o=0.
2. MAX_BB_LEN=4, enable_i=1: four 0x00000013, then 0x0000006F → bb_len_o 1,2,3,4 then 0; max_seen_o=4; disc_count_o=1; filler_count_o=1; violation_o never 1.
3. MAX_BB_LEN=4: five 0x00000013 → violation_o=1 exactly one cycle after the fifth accept; alarm_o=1; violation_instr_o=0x00000013; bb_len_o=5. Further instructions leave everything frozen. clear_i → alarm_o=0, all counters 0, state MONITOR.
4. Compressed: two 0x0001 (c.nop), 0xA001 (c.j) → bb_len_o 0. Then 0x8082 (c.jr ra) → disc_count_o+1. Then 0x8086 (c.mv, rs2≠0) → bb_len_o=1.
5. Bubbles and near misses:
   - instr_i=0 with valid=1 → no change
   - valid=0 with 0x00000013 → no change
   - 0x00001067 (JALR funct3=001) → counted as non-discontinuity
6. With disc_count_o preloaded near saturation (CNT_W=4): 20 branches 0x00000063 → disc_count_o=15 and holds.
